// File: rtl/seven_segment_pkg.sv
// Shared definitions for the seven-segment scanner and decoder.
// Holds digit width, the scan state type and the inactive-enable helper.
package seven_segment_pkg;

    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned MAX_DIGITS = 8;

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    // Enable vector with every digit off, for the requested polarity.
    function automatic logic [MAX_DIGITS-1:0] inactive_enables(input logic active_low);
        return active_low ? {MAX_DIGITS{1'b1}} : {MAX_DIGITS{1'b0}};
    endfunction

endpackage

// File: rtl/seven_segment_slot_timer.sv
// Per-digit slot timer: slot counter, slot-end strobe and BLANK/SHOW state.
// o_show_next is the state the register takes on the coming edge.
module seven_segment_slot_timer
    import seven_segment_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 12000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic CLK_IN,
    input  logic RST_N_IN,
    output logic o_slot_end,
    output logic o_show_next
);

    localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_next;
    scan_state_t   r_state;
    scan_state_t   w_state_next;
    logic          w_slot_end;

    assign w_slot_end   = (r_count == CW'(REFRESH_DIV - 1));
    assign w_count_next = w_slot_end ? '0 : r_count + 1'b1;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            BLANK: if (w_count_next == CW'(BLANK_CYCLES)) w_state_next = SHOW;
            SHOW:  if (w_slot_end)                        w_state_next = BLANK;
        endcase
    end

    always_ff @(posedge CLK_IN or negedge RST_N_IN) begin
        if (!RST_N_IN) begin
            r_count <= '0;
            r_state <= BLANK;
        end else begin
            r_count <= w_count_next;
            r_state <= w_state_next;
        end
    end

    assign o_slot_end  = w_slot_end;
    assign o_show_next = (w_state_next == SHOW);

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed N-digit hex scanner feeding a registered 7-segment decoder.
// Optional feature macro: LEADING_ZERO_BLANK_EN (suppress leading-zero digits).
module seven_segment_scanner
    import seven_segment_pkg::*;
#(
    parameter int unsigned NUM_DIGITS       = 4,
    parameter int unsigned REFRESH_DIV      = 12000,
    parameter int unsigned BLANK_CYCLES     = 16,
    parameter bit          DIGIT_ACTIVE_LOW = 1'b1
) (
    input  logic                          CLK_IN,
    input  logic                          RST_N_IN,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] VALUE_IN,
    input  logic                          LOAD_IN,
    output logic [DIGIT_W-1:0]            NUMBER_OUT,
    output logic [NUM_DIGITS-1:0]         DIGIT_EN_OUT,
    output logic                          BLANK_OUT,
    output logic                          FRAME_OUT
);

    localparam int unsigned IW = $clog2(NUM_DIGITS);
    localparam int unsigned VW = DIGIT_W * NUM_DIGITS;
    localparam logic [MAX_DIGITS-1:0] EN_OFF_ALL = inactive_enables(DIGIT_ACTIVE_LOW);
    localparam logic [NUM_DIGITS-1:0] EN_OFF     = EN_OFF_ALL[NUM_DIGITS-1:0];

    logic                  w_slot_end;
    logic                  w_show_next;
    logic                  w_frame_wrap;
    logic                  w_suppress_next;
    logic                  w_show_gated;
    logic [IW-1:0]         w_idx_next;
    logic [VW-1:0]         w_display_next;
    logic [DIGIT_W-1:0]    w_digit_sel;
    logic [NUM_DIGITS-1:0] w_onehot;
    logic [NUM_DIGITS-1:0] w_en_active;

    logic [IW-1:0]         r_idx;
    logic [VW-1:0]         r_shadow;
    logic [VW-1:0]         r_display;
    logic                  r_pending;
    logic [DIGIT_W-1:0]    r_number;
    logic [NUM_DIGITS-1:0] r_digit_en;
    logic                  r_blank;
    logic                  r_frame;

    seven_segment_slot_timer #(
        .REFRESH_DIV  (REFRESH_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_slot_timer (
        .CLK_IN      (CLK_IN),
        .RST_N_IN    (RST_N_IN),
        .o_slot_end  (w_slot_end),
        .o_show_next (w_show_next)
    );

    assign w_frame_wrap = w_slot_end && (r_idx == IW'(NUM_DIGITS - 1));

    always_comb begin
        w_idx_next = r_idx;
        if (w_slot_end) w_idx_next = w_frame_wrap ? '0 : r_idx + 1'b1;
    end

    // Display only changes at the frame wrap; a load landing on the wrap bypasses the shadow.
    always_comb begin
        w_display_next = r_display;
        if (w_frame_wrap) begin
            if (LOAD_IN)        w_display_next = VALUE_IN;
            else if (r_pending) w_display_next = r_shadow;
        end
    end

    assign w_digit_sel = w_display_next[w_idx_next*DIGIT_W +: DIGIT_W];

`ifdef LEADING_ZERO_BLANK_EN
    // w_upper_zero[k]: display digits k..NUM_DIGITS-1 are all zero.
    logic [NUM_DIGITS-1:0] w_upper_zero;

    always_comb begin
        w_upper_zero = '0;
        w_upper_zero[NUM_DIGITS-1] = (w_display_next[VW-1 -: DIGIT_W] == '0);
        for (int unsigned j = 1; j < NUM_DIGITS; j++) begin
            w_upper_zero[NUM_DIGITS-1-j] = w_upper_zero[NUM_DIGITS-j] &&
                (w_display_next[(NUM_DIGITS-1-j)*DIGIT_W +: DIGIT_W] == '0);
        end
    end

    assign w_suppress_next = (w_idx_next != '0) && w_upper_zero[w_idx_next];
`else
    assign w_suppress_next = 1'b0;
`endif

    always_comb begin
        w_onehot = '0;
        w_onehot[w_idx_next] = 1'b1;
    end

    assign w_en_active  = DIGIT_ACTIVE_LOW ? ~w_onehot : w_onehot;
    assign w_show_gated = w_show_next && !w_suppress_next;

    always_ff @(posedge CLK_IN or negedge RST_N_IN) begin
        if (!RST_N_IN) begin
            r_idx     <= '0;
            r_shadow  <= '0;
            r_display <= '0;
            r_pending <= 1'b0;
        end else begin
            r_idx     <= w_idx_next;
            r_display <= w_display_next;
            if (w_frame_wrap) begin
                r_pending <= 1'b0;
            end else if (LOAD_IN) begin
                r_shadow  <= VALUE_IN;
                r_pending <= 1'b1;
            end
        end
    end

    // Outputs are registered against next-state values so they line up with the slot count.
    always_ff @(posedge CLK_IN or negedge RST_N_IN) begin
        if (!RST_N_IN) begin
            r_number   <= '0;
            r_digit_en <= EN_OFF;
            r_blank    <= 1'b1;
            r_frame    <= 1'b0;
        end else begin
            if (w_slot_end) r_number <= w_digit_sel;
            r_digit_en <= w_show_gated ? w_en_active : EN_OFF;
            r_blank    <= !w_show_gated;
            r_frame    <= w_frame_wrap;
        end
    end

    assign NUMBER_OUT   = r_number;
    assign DIGIT_EN_OUT = r_digit_en;
    assign BLANK_OUT    = r_blank;
    assign FRAME_OUT    = r_frame;

endmodule
